// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - queued 8x8 one-bit sprite blitter into a 256x256 byte framebuffer
// Command FIFO feeds a FETCH/LATCH/DRAW engine that writes one clipped pixel per cycle.
module sprite_blitter #(
  parameter int CMD_DEPTH       = 4,
  parameter int SPRITE_ID_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_x,
  input  logic [7:0]                 cmd_y,
  input  logic [SPRITE_ID_WIDTH-1:0] cmd_sprite,
  input  logic [7:0]                 cmd_color,
  input  logic                       cmd_erase,
  output logic [SPRITE_ID_WIDTH+2:0] spr_addr,
  input  logic [7:0]                 spr_data,
  output logic                       fb_we,
  output logic [15:0]                fb_addr,
  output logic [7:0]                 fb_wdata,
  output logic                       busy,
  output logic                       done
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int SW = SPRITE_ID_WIDTH;
  localparam int EW = 25 + SW;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, DRAW} state_t;

  logic [EW-1:0] fifo_q [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push, pop;
  logic [7:0]    head_x, head_y, head_color;
  logic [SW-1:0] head_spr;
  logic          head_erase;

  state_t        state_q;
  logic [2:0]    row_q, col_q, row_d;
  logic [7:0]    bits_q, x_q, y_q, color_q;
  logic [SW-1:0] spr_q;
  logic          erase_q;
  logic [SW+2:0] spr_addr_q;
  logic          fb_we_q, done_q;
  logic [15:0]   fb_addr_q;
  logic [7:0]    fb_wdata_q;
  logic [8:0]    px_sum, py_sum;
  logic          pix_on, clip, wr_d;

  assign cmd_ready = !rst && (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign busy      = (count_q != '0) || (state_q != IDLE);
  assign {head_x, head_y, head_spr, head_color, head_erase} = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_x, cmd_y, cmd_sprite, cmd_color, cmd_erase};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // 9-bit sums: a carry means the pixel falls off the right or bottom edge.
  always_comb begin
    row_d  = row_q + 3'd1;
    px_sum = {1'b0, x_q} + {6'b0, col_q};
    py_sum = {1'b0, y_q} + {6'b0, row_q};
    clip   = px_sum[8] | py_sum[8];
    pix_on = bits_q[3'd7 - col_q];
    wr_d   = pix_on && !clip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      bits_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      spr_q      <= '0;
      erase_q    <= 1'b0;
      spr_addr_q <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      done_q     <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            x_q        <= head_x;
            y_q        <= head_y;
            spr_q      <= head_spr;
            color_q    <= head_color;
            erase_q    <= head_erase;
            row_q      <= '0;
            spr_addr_q <= {head_spr, 3'd0};
            state_q    <= FETCH;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          bits_q  <= spr_data;
          col_q   <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          fb_we_q <= wr_d;
          // Address/data only move on a real write so they hold otherwise.
          if (wr_d) begin
            fb_addr_q  <= {py_sum[7:0], px_sum[7:0]};
            fb_wdata_q <= erase_q ? 8'h00 : color_q;
          end
          col_q <= col_q + 3'd1;
          if (col_q == 3'd7) begin
            if (row_q == 3'd7) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              row_q      <= row_d;
              spr_addr_q <= {spr_q, row_d};
              state_q    <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spr_addr = spr_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign done     = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter
module tb_sprite_blitter;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_x = '0, cmd_y = '0, cmd_color = '0;
  logic [SW-1:0] cmd_sprite = '0;
  logic          cmd_erase = 1'b0;
  logic [SW+2:0] spr_addr;
  logic [7:0]    spr_data = '0;
  logic          fb_we;
  logic [15:0]   fb_addr;
  logic [7:0]    fb_wdata;
  logic          busy, done;

  sprite_blitter #(.CMD_DEPTH(4), .SPRITE_ID_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_sprite(cmd_sprite), .cmd_color(cmd_color),
    .cmd_erase(cmd_erase), .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]  spr_mem [0:511];
  logic [23:0] exp_q [$];
  int n_total = 0, n_bad = 0;
  int cyc = 0, wr_seen = 0, done_cnt = 0, done_cyc = 0, first_we_cyc = -1;
  int pending = 0, last_push_cyc = 0;
  logic [23:0] mon_e;
  logic [31:0] mon_ea;
  logic [7:0]  mon_ed;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) spr_data <= spr_mem[spr_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input int x, input int y, input int spr, input int color, input bit er);
    logic [7:0] rb, ax, ay, d;
    for (int r = 0; r < 8; r++) begin
      rb = spr_mem[spr*8 + r];
      for (int c = 0; c < 8; c++) begin
        if (rb[7-c] && (x + c) < 256 && (y + r) < 256) begin
          ax = 8'(x + c);
          ay = 8'(y + r);
          d  = er ? 8'h00 : 8'(color);
          exp_q.push_back({ay, ax, d});
        end
      end
    end
  endtask

  task automatic push_cmd(input int x, input int y, input int spr, input int color, input bit er,
                          output bit acc);
    @(negedge clk);
    cmd_x = 8'(x); cmd_y = 8'(y); cmd_sprite = SW'(spr); cmd_color = 8'(color);
    cmd_erase = er; cmd_valid = 1'b1;
    acc = cmd_ready;
    if (acc) begin
      push_expect(x, y, spr, color, er);
      pending++;
      last_push_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 8'($urandom); cmd_sprite = SW'($urandom);
    cmd_color = 8'($urandom); cmd_erase = 1'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_cnt", done_cnt, target);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we) begin
        wr_seen++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        if (exp_q.size() > 0) begin
          mon_e  = exp_q.pop_front();
          mon_ea = {16'b0, mon_e[23:8]};
          mon_ed = mon_e[7:0];
        end else begin
          mon_ea = 32'h1_0000;
          mon_ed = 8'h00;
        end
        check_eq("wr_addr", {16'b0, fb_addr}, mon_ea);
        check_eq("wr_data", {24'b0, fb_wdata}, {24'b0, mon_ed});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("busy_at_done", busy, pending > 1);
        pending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base, dbase, n;
    int spr_list [6] = '{2, 1, 0, 2, 3, 2};

    for (int i = 0; i < 512; i++) spr_mem[i] = 8'($urandom);
    for (int r = 0; r < 8; r++) begin
      spr_mem[0*8 + r] = 8'hFF;
      spr_mem[1*8 + r] = 8'hAA;
      spr_mem[3*8 + r] = 8'hFF;
    end

    #1;
    check_eq("rst_ready_low", cmd_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fb_we", fb_we, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_ready", cmd_ready, 1);
    check_eq("rel_busy", busy, 0);
    check_eq("rel_done", done, 0);
    check_eq("rel_fb_we", fb_we, 0);
    check_eq("rel_spr_addr", {23'b0, spr_addr}, 0);
    check_eq("rel_fb_addr", {16'b0, fb_addr}, 0);
    check_eq("rel_fb_wdata", {24'b0, fb_wdata}, 0);

    // Single solid sprite with latency checks
    base = wr_seen; first_we_cyc = -1;
    push_cmd(10, 20, 0, 8'h5A, 1'b0, acc);
    check_eq("t1_acc", acc, 1);
    wait_done(1, 200);
    check_eq("t1_writes", wr_seen - base, 64);
    check_eq("t1_first_we", first_we_cyc - last_push_cyc, 4);
    check_eq("t1_done_lat", done_cyc - last_push_cyc, 81);
    check_eq("t1_q_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("t1_busy_after", busy, 0);

    // Checkerboard: transparent zero bits
    base = wr_seen;
    push_cmd(100, 100, 1, 8'h33, 1'b0, acc);
    wait_done(2, 200);
    check_eq("t2_writes", wr_seen - base, 32);

    // Clipping at bottom-right corner
    base = wr_seen;
    push_cmd(252, 250, 0, 8'h77, 1'b0, acc);
    wait_done(3, 200);
    check_eq("t3_writes", wr_seen - base, 24);
    check_eq("t3_q_empty", exp_q.size(), 0);

    // Erase
    base = wr_seen;
    push_cmd(0, 0, 3, 8'hFF, 1'b1, acc);
    wait_done(4, 200);
    check_eq("t4_writes", wr_seen - base, 64);

    // Backpressure: six back-to-back offers, five fit
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push_cmd(i*40, i*30, spr_list[i], 8'h10 + i, 1'(i == 3), acc);
      check_eq($sformatf("bp_acc%0d", i), acc, i < 5);
    end
    wait_done(9, 700);
    check_eq("bp_q_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("bp_busy_after", busy, 0);
    check_eq("bp_ready_after", cmd_ready, 1);

    // Reset mid-blit with two commands queued
    base = wr_seen;
    push_cmd(50, 60, 0, 8'h21, 1'b0, acc);
    push_cmd(70, 80, 0, 8'h22, 1'b0, acc);
    push_cmd(90, 100, 0, 8'h23, 1'b0, acc);
    n = 0;
    while (wr_seen - base < 30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach30", wr_seen - base, 30);
    #2;
    rst = 1'b1;
    exp_q.delete();
    pending = 0;
    #1;
    check_eq("mid_rst_fb_we", fb_we, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = wr_seen; dbase = done_cnt;
    repeat (250) @(negedge clk);
    check_eq("post_rst_writes", wr_seen - base, 0);
    check_eq("post_rst_done", done_cnt - dbase, 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_ready", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Downstream graphics stage fed by the CPU's execute-stage sprite draw path. Accepts queued draw commands (screen x/y, sprite index, colour, erase flag) and blits 8x8 one-bit sprite bitmaps from sprite memory into the 256x256 byte-per-pixel framebuffer. Writes one pixel per cycle, with transparency and edge clipping. Raises backpressure through `cmd_ready` so the CPU can stall the instruction that issues the command.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `SPRITE_ID_WIDTH`, 6: sprite index width (64 sprites)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `cmd_valid`  in  1  command offered this cycle
- `cmd_ready`  out  1  FIFO not full; a push occurs when `cmd_valid && cmd_ready`
- `cmd_x`  in  8  sprite left column
- `cmd_y`  in  8  sprite top row
- `cmd_sprite`  in  SPRITE_ID_WIDTH  sprite index
- `cmd_color`  in  8  pixel colour for set bits
- `cmd_erase`  in  1  1 = write 0x00 instead of `cmd_color`
- `spr_addr`  out  SPRITE_ID_WIDTH+3  {sprite, row} sprite-memory read address
- `spr_data`  in  8  row bitmap, valid 1 cycle after `spr_addr`; bit 7 = column 0
- `fb_we`  out  1  framebuffer pixel write strobe
- `fb_addr`  out  16  {y, x} pixel address
- `fb_wdata`  out  8  pixel value
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `done`  out  1  one-cycle pulse at the end of each command

## Operation
- FIFO stores {x, y, sprite, color, erase}. Its occupancy counter has width log2(CMD_DEPTH)+1.
- Push and pop in the same cycle leave the count unchanged. A push is never accepted while full, including a full FIFO that pops in the same cycle.
- FSM states: IDLE, FETCH, LATCH, DRAW.
- IDLE: if the FIFO is non-empty, pop the head into working registers, set row=0, and go to FETCH. Otherwise stay.
- FETCH: drive `spr_addr={sprite,row}`, then go to LATCH.
- LATCH: capture `spr_data` into the row register, set col=0, then go to DRAW.
- DRAW: one cycle per column.
  - `fb_we = bit[7-col] && !clip`.
  - `fb_addr = {y+row, x+col}`.
  - `fb_wdata = erase ? 0x00 : color`.
  - Pixel sums are formed 9 bits wide. `clip` = carry out of either sum, so there is no wrap-around.
  - Zero bits are transparent and produce no write.
  - At col=7: if row=7, pulse `done` and go to IDLE. Otherwise increment row and go to FETCH.
- `fb_addr` and `fb_wdata` are don't-care when `fb_we=0`. The implementation holds them at their last value.
- `spr_addr` holds its value outside FETCH.

## Timing
- Reset values:
  - `cmd_ready`=1 once reset deasserts (0 while `rst` is high).
  - `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `spr_addr`=0, `busy`=0, `done`=0.
  - FIFO empty, FSM in IDLE.
- All outputs are registered except `cmd_ready` and `busy`, which are combinational from state and count.
- Per command: 1 IDLE cycle + 8 rows × (FETCH + LATCH + 8 DRAW) = 81 cycles from pop to the end of the `done` cycle.
- `done` is asserted in the cycle after the final DRAW write. The next command pops in the IDLE cycle coinciding with `done`.
- A command pushed into an empty idle block pops on the next edge. The first `fb_we` can appear 4 cycles after the push edge.
- Command data is sampled only at the push edge. Later input changes have no effect on a queued command.
- Reset asserted mid-blit:
  - FIFO and FSM clear immediately.
  - `fb_we` drops asynchronously.
  - No further writes occur for the interrupted command.
- `busy` drops in the same cycle `done` is high only if the FIFO is empty.

## Test plan
- Single sprite, all-ones bitmap, x=10, y=20, color=0x5A → 64 writes covering addresses {20..27, 10..17} in row-major order. `done` pulses 81 cycles after the pop.
- Checkerboard 0xAA rows → only columns 0,2,4,6 are written per row (32 writes total). Zero bits produce no `fb_we`.
- Clipping: x=252, y=250, all-ones → writes only cols 0–3, rows 0–5 (24 writes). No address wraps to x<252 or y<250.
- Erase: x=0, y=0, color=0xFF, erase=1, all-ones → 64 writes with `fb_wdata`=0x00.
- Backpressure with CMD_DEPTH=4: push 6 back-to-back → `cmd_ready` falls after 5 accepted (1 popped plus 4 queued). All accepted commands complete in order with 5 `done` pulses. `busy` falls after the last one.
- Reset at DRAW cycle 30 of a command with 2 more queued → zero `fb_we` after reset. `busy`=0 and `cmd_ready`=1 after release. No `done` pulse.
